// File: rtl/adder_share_arbiter_if.sv
// adder_share_arbiter_if
//   Handshake bundle between the requesters/consumer (master) and the shared
//   adder arbiter (slave).
//   i_req        per-requester request flags, bit k = requester k
//   i_add_term1  first operands, slice [k*WIDTH +: WIDTH] = requester k
//   i_add_term2  second operands, same slicing
//   i_ready      consumer acceptance of o_result/o_id
//   o_grant      one-hot (or zero) grant, combinational, in the capture cycle
//   o_valid      o_result/o_id hold a completed sum
//   o_result     registered sum, MSB = carry-out
//   o_id         index of the requester that produced o_result
//   o_op_count   grants issued since reset (wraps)
interface adder_share_arbiter_if #(
  parameter int WIDTH = 14,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       i_req;
  logic [NREQ*WIDTH-1:0] i_add_term1;
  logic [NREQ*WIDTH-1:0] i_add_term2;
  logic                  i_ready;
  logic [NREQ-1:0]       o_grant;
  logic                  o_valid;
  logic [WIDTH:0]        o_result;
  logic [IDW-1:0]        o_id;
  logic [15:0]           o_op_count;

  modport master (
    output i_req, i_add_term1, i_add_term2, i_ready,
    input  o_grant, o_valid, o_result, o_id, o_op_count
  );

  modport slave (
    input  i_req, i_add_term1, i_add_term2, i_ready,
    output o_grant, o_valid, o_result, o_id, o_op_count
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
//   NREQ requesters share one WIDTH-bit ripple-carry adder. A round-robin
//   arbiter picks one requester per cycle whenever the single-entry output
//   register can take a result; the sum appears one cycle after the grant.
//   Ports:
//     i_clk  clock, rising edge
//     i_rst  asynchronous active-high reset
//     bus    adder_share_arbiter_if.slave (request/operand/result handshake)

// One bit of the ripple chain.
module adder_share_arbiter_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder_share_arbiter #(
  parameter int WIDTH = 14,
  parameter int NREQ  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  adder_share_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                      state;
  logic [IDW-1:0]              ptr;
  logic [IDW-1:0]              gnt_idx;
  logic [IDW-1:0]              idx;
  logic                        gnt_any;
  logic                        can_accept;
  logic                        gnt_fire;
  logic [NREQ-1:0][WIDTH-1:0]  term1;
  logic [NREQ-1:0][WIDTH-1:0]  term2;
  logic [WIDTH-1:0]            op_a;
  logic [WIDTH-1:0]            op_b;
  logic [WIDTH-1:0]            sum;
  logic [WIDTH:0]              carry;

  logic                        valid_q;
  logic [WIDTH:0]              result_q;
  logic [IDW-1:0]              id_q;
  logic [15:0]                 cnt_q;

  // Flat operand buses reinterpreted as per-requester lanes.
  assign term1 = bus.i_add_term1;
  assign term2 = bus.i_add_term2;

  // Output slot frees up this cycle if empty or being drained.
  assign can_accept = (state == EMPTY) || bus.i_ready;

  // Round-robin: scan offsets high to low so the lowest offset from ptr wins.
  // ptr + i wraps naturally because NREQ is a power of two.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = ptr + IDW'(i);
      if (bus.i_req[idx]) begin
        gnt_idx = idx;
        gnt_any = 1'b1;
      end
    end
  end

  assign gnt_fire    = gnt_any && can_accept && !i_rst;
  assign bus.o_grant = gnt_fire ? (NREQ'(1) << gnt_idx) : '0;

  // Shared adder: operand mux feeding a single ripple chain, carry-in 0.
  assign op_a     = term1[gnt_idx];
  assign op_b     = term2[gnt_idx];
  assign carry[0] = 1'b0;

  adder_share_arbiter_fa u_fa [WIDTH-1:0] (
    .a  (op_a),
    .b  (op_b),
    .ci (carry[WIDTH-1:0]),
    .s  (sum),
    .co (carry[WIDTH:1])
  );

  // EMPTY/FULL output slot with registered result, id and grant counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= EMPTY;
      valid_q  <= 1'b0;
      result_q <= '0;
      id_q     <= '0;
      ptr      <= '0;
      cnt_q    <= '0;
    end else if (gnt_fire) begin
      // Covers both load-from-empty and drain-and-reload in one cycle.
      state    <= FULL;
      valid_q  <= 1'b1;
      result_q <= {carry[WIDTH], sum};
      id_q     <= gnt_idx;
      ptr      <= gnt_idx + IDW'(1);
      cnt_q    <= cnt_q + 16'd1;
    end else if (state == FULL && bus.i_ready) begin
      // Drained with nothing to replace it; result/id keep last value.
      state    <= EMPTY;
      valid_q  <= 1'b0;
    end
  end

  assign bus.o_valid    = valid_q;
  assign bus.o_result   = result_q;
  assign bus.o_id       = id_q;
  assign bus.o_op_count = cnt_q;
endmodule
